// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand loader: FSM state codes, debounce default
// and the captured operand bundle.
package alu_pkg;

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    localparam int DEBOUNCE_DEFAULT = 250000;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       cin;
    } operands_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge pulse for one raw
// push-button. The pulse is high for the single cycle after the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level toggles on the edge where the counter would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads operands A, B and carry-in for a 2-bit adder from switches, one
// debounced load press at a time; a clear press restarts the sequence.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       sw_cin,
    input  logic       btn_load,
    input  logic       btn_clr,
    output logic       a0,
    output logic       a1,
    output logic       b0,
    output logic       b1,
    output logic       cin,
    output logic       op_valid,
    output logic [1:0] state
);

    logic      load_pulse;
    logic      clr_pulse;
    logic [2:0] sw_meta;
    logic [2:0] sw_sync;
    operands_t ops;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_load),
        .pulse (load_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (clr_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {sw_cin, sw};
            sw_sync <= sw_meta;
        end
    end

    // Clear outranks load; the illegal code 2'b11 falls back to S_A without capturing.
    always_ff @(posedge clk) begin
        if (rst || clr_pulse) begin
            state <= S_A;
            ops   <= '0;
        end else begin
            case (state)
                S_A: begin
                    if (load_pulse) begin
                        ops.a <= sw_sync[1:0];
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (load_pulse) begin
                        ops.b   <= sw_sync[1:0];
                        ops.cin <= sw_sync[2];
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (load_pulse) begin
                        ops.a <= sw_sync[1:0];
                        state <= S_B;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    // op_valid is a pure decode of the state, so it can never disagree with S_HOLD.
    assign op_valid = (state == S_HOLD);
    assign a1  = ops.a[1];
    assign a0  = ops.a[0];
    assign b1  = ops.b[1];
    assign b0  = ops.b[0];
    assign cin = ops.cin;

endmodule
